// File: rtl/imm_encode.sv
// Packs a 32-bit immediate into the I/S/B/U/J fields of an RV32I word and
// queues {word, err} in a small output FIFO. Optional counters: IMM_ENCODE_STATS_EN.
module imm_encode #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_type,
  input  logic [31:0]      imm_in,
  input  logic [31:0]      base_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [2:0] T_I = 3'b001;
  localparam logic [2:0] T_B = 3'b010;
  localparam logic [2:0] T_U = 3'b011;
  localparam logic [2:0] T_J = 3'b100;
  localparam logic [2:0] T_S = 3'b101;

  // Returns {err, word}; out-of-range immediates are still packed from truncated bits.
  function automatic logic [32:0] encode(input logic [2:0]  t,
                                         input logic [31:0] imm,
                                         input logic [31:0] base);
    logic signed [31:0] s;
    logic [31:0]        w;
    logic               e;
    s = $signed(imm);
    w = base;
    e = 1'b1;
    case (t)
      T_I: begin
        w = {imm[11:0], base[19:0]};
        e = (s < -32'sd2048) || (s > 32'sd2047);
      end
      T_S: begin
        w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        e = (s < -32'sd2048) || (s > 32'sd2047);
      end
      T_B: begin
        w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        e = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
      end
      T_U: begin
        w = {imm[31:12], base[11:0]};
        e = |imm[11:0];
      end
      T_J: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        e = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
      end
      default: begin
        w = base;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  logic [32:0]   enc;
  logic          push, pop;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   head_d;
  logic [31:0]   out_word_q;
  logic          out_err_q;

  assign enc       = encode(imm_type, imm_in, base_in);
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_word  = out_word_q;
  assign out_err   = out_err_q;

  always_comb begin
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    // The new head is the entry being written only when the queue drains to it this cycle.
    head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? enc : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_word_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (count_d != '0) {out_err_q, out_word_q} <= head_d;
    end
  end

`ifdef IMM_ENCODE_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_ok_q, cnt_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (push) begin
      if (enc[32]) cnt_err_q <= sat_inc(cnt_err_q);
      else         cnt_ok_q  <= sat_inc(cnt_ok_q);
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_err = cnt_err_q;
`else
  assign cnt_ok  = '0;
  assign cnt_err = '0;
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Directed self-checking bench for imm_encode: field packing, legality,
// FIFO backpressure/ordering, async reset and (if enabled) counter saturation.
module tb_imm_encode;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       imm_type;
  logic [31:0]      imm_in;
  logic [31:0]      base_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_word;
  logic             out_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  int tests = 0;
  int fails = 0;
  int exp_ok = 0;
  int exp_err = 0;

  imm_encode #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .imm_in(imm_in), .base_in(base_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_err(out_err),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the request is accepted.
  task automatic push(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
    int n;
    imm_type = t; imm_in = imm; base_in = base; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [2:0] t, input logic [31:0] imm,
                      input logic [31:0] base, input logic [31:0] ew, input logic ee);
    out_ready = 1'b1;
    push(t, imm, base);
    if (ee) exp_err++; else exp_ok++;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"},  out_word, ew);
    chk({tag, "_err"},   32'(out_err), 32'(ee));
    @(negedge clk);
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic chk_stats(input string tag);
`ifdef IMM_ENCODE_STATS_EN
    chk({tag, "_cnt_ok"},  32'(cnt_ok),  32'(exp_ok));
    chk({tag, "_cnt_err"}, 32'(cnt_err), 32'(exp_err));
`else
    chk({tag, "_cnt_ok"},  32'(cnt_ok),  32'd0);
    chk({tag, "_cnt_err"}, 32'(cnt_err), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm_type = 3'b000; imm_in = '0; base_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_word",  out_word,       32'h0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk_stats("rst");
    rst_n = 1'b1;
    @(negedge clk);

    xfer("i_neg1", 3'b001, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    xfer("b_8",    3'b010, 32'h0000_0008, 32'h0000_0063, 32'h0000_0463, 1'b0);
    xfer("j_800",  3'b100, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    xfer("s_neg4", 3'b101, 32'hFFFF_FFFC, 32'h0000_0023, 32'hFE00_0E23, 1'b0);
    xfer("u_ok",   3'b011, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    xfer("u_bad",  3'b011, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);
    xfer("i_2048", 3'b001, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    xfer("b_6",    3'b010, 32'h0000_0006, 32'h0000_0063, 32'h0000_0363, 1'b0);
    xfer("b_7",    3'b010, 32'h0000_0007, 32'h0000_0063, 32'h0000_0363, 1'b1);
    xfer("j_min",  3'b100, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);
    xfer("t_110",  3'b110, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    chk_stats("after_directed");

    // Backpressure: fill both entries, third request stalls.
    out_ready = 1'b0;
    push(3'b001, 32'd1, 32'h13);
    push(3'b001, 32'd2, 32'h13);
    exp_ok += 2;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head",     out_word, 32'h0010_0013);
    imm_type = 3'b001; imm_in = 32'd3; base_in = 32'h13; in_valid = 1'b1;
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_head",     out_word, 32'h0010_0013);
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop1_word",     out_word, 32'h0020_0013);
    chk("pop1_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_ok++;
    chk("pushpop_valid", 32'(out_valid), 32'd1);
    chk("pushpop_word",  out_word, 32'h0030_0013);
    @(negedge clk);
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_hold",  out_word, 32'h0030_0013);
    chk_stats("after_bp");

    // Reset with two entries queued.
    out_ready = 1'b0;
    push(3'b001, 32'd4, 32'h13);
    push(3'b001, 32'd5, 32'h13);
    exp_ok += 2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk_stats("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid",    32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready),  32'd1);
    chk("midrst_word",     out_word, 32'h0);
    exp_ok = 0; exp_err = 0;
    chk_stats("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    xfer("post_rst", 3'b001, 32'h0000_07FF, 32'h13, 32'h7FF0_0013, 1'b0);

`ifdef IMM_ENCODE_STATS_EN
    imm_type = 3'b001; imm_in = 32'd0; base_in = 32'h13; in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sat_cnt_ok",  32'(cnt_ok),  32'h0000_FFFF);
    chk("sat_cnt_err", 32'(cnt_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
